// File: rtl/keyscan_drv.sv
// Key matrix scanner: active-low column strobes, debounced press/release events via valid/ack.
// Optional ghost filtering of multi-row column samples: define KEYSCAN_GHOST_BLOCK_EN.
module keyscan_drv #(
  parameter int COLS   = 8,
  parameter int ROWS   = 4,
  parameter int DIV_W  = 4,
  parameter int DEB_N  = 3,
  parameter int CODE_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [COLS-1:0]   col,
  input  logic [ROWS-1:0]   row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_down,
  output logic              key_valid,
  input  logic              key_ack
);

  localparam int NK    = COLS * ROWS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [3:0] CNT_MAX = 4'(DEB_N - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [COL_W-1:0]  col_idx;
  logic [COL_W-1:0]  col_nxt;
  logic [COL_W-1:0]  samp_col;
  logic [ROWS-1:0]   row_s1;
  logic [ROWS-1:0]   row_s2;
  logic [ROWS-1:0]   sample;
  logic [NK-1:0]     stable;
  logic [3:0]        cnt [NK];

  logic              dwell_end;
  logic              ghost;
  logic              eval_en;
  logic [ROW_W-1:0]  eval_row;
  logic [CODE_W-1:0] eval_key;
  logic              eval_bit;

  assign dwell_end = &div_cnt;
  assign col_nxt   = !dwell_end ? col_idx :
                     (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);

`ifdef KEYSCAN_GHOST_BLOCK_EN
  // Two or more rows down in one column can hide a phantom key; skip that column.
  assign ghost = ($countones(sample) > 1);
`else
  assign ghost = 1'b0;
`endif

  // One row of the previously sampled column is evaluated per cycle at dwell counts 1..ROWS.
  assign eval_en  = (div_cnt >= DIV_W'(1)) && (div_cnt <= DIV_W'(ROWS)) && !ghost;
  assign eval_row = ROW_W'(div_cnt - DIV_W'(1));
  assign eval_key = CODE_W'(samp_col) * CODE_W'(ROWS) + CODE_W'(eval_row);
  assign eval_bit = sample[eval_row];

  // Handshake: key_valid holds with key_code/key_down stable until a cycle with
  // key_valid & key_ack; it drops on that edge and a new event may load one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      col_idx   <= '0;
      col       <= '1;
      row_s1    <= '1;
      row_s2    <= '1;
      sample    <= '0;
      samp_col  <= '0;
      stable    <= '0;
      key_code  <= '0;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      col_idx <= col_nxt;
      col     <= ~(COLS'(1) << col_nxt);
      row_s1  <= row;
      row_s2  <= row_s1;

      if (dwell_end) begin
        sample   <= ~row_s2;
        samp_col <= col_idx;
      end

      if (key_valid && key_ack) key_valid <= 1'b0;

      if (eval_en) begin
        if (eval_bit == stable[eval_key]) begin
          cnt[eval_key] <= '0;
        end else if (cnt[eval_key] < CNT_MAX) begin
          cnt[eval_key] <= cnt[eval_key] + 4'd1;
        end else if (!key_valid) begin
          key_code         <= eval_key;
          key_down         <= eval_bit;
          key_valid        <= 1'b1;
          stable[eval_key] <= eval_bit;
          cnt[eval_key]    <= '0;
        end
        // Register full: counter stays saturated so the change is retried next frame.
      end
    end
  end

endmodule

// File: tb/tb_keyscan_drv.sv
// Directed bench for keyscan_drv: table of key patterns with expected events plus
// hand sequences for reset timing, bounce, backpressure and reset during a pending event.
module tb_keyscan_drv;

  localparam int FRAME  = 128;
  localparam int PRESS_BOUND = 3 * 128 + 16 + 7;
`ifdef KEYSCAN_GHOST_BLOCK_EN
  localparam int GHOST_EV = 0;
`else
  localparam int GHOST_EV = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  col;
  logic [3:0]  row;
  logic [4:0]  key_code;
  logic        key_down;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic [31:0] pressed = '0;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] mask;
    int          n_ev;
    logic [4:0]  c0;
    logic [4:0]  c1;
    logic        down;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  keyscan_drv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_down  (key_down),
    .key_valid (key_valid),
    .key_ack   (key_ack)
  );

  // Passive key matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = '1;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_event(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (key_valid) got = 1'b1;
    end
  endtask

  task automatic ack_pulse(input string name);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    chk({name, " drop"}, {31'd0, key_valid}, 32'd0);
  endtask

  task automatic take_event(input string name, input int bound,
                            input logic [4:0] exp_code, input logic exp_down);
    bit got;
    wait_event(bound, got);
    chk({name, " valid"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({name, " code"}, {27'd0, key_code}, {27'd0, exp_code});
      chk({name, " down"}, {31'd0, key_down}, {31'd0, exp_down});
      ack_pulse(name);
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    chk({name, " quiet"}, {31'd0, seen}, 32'd0);
  endtask

  task automatic wait_col0();
    bit ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (col == 8'hFE) ok = 1'b1;
    end
    chk("col0 align", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    bit got;
    bit bad;

    vecs[0] = '{"key9 press",    32'h0000_0200, 1, 5'd9,  5'd0,  1'b1};
    vecs[1] = '{"key9 release",  32'h0000_0000, 1, 5'd9,  5'd0,  1'b0};
    vecs[2] = '{"key0 press",    32'h0000_0001, 1, 5'd0,  5'd0,  1'b1};
    vecs[3] = '{"key0 release",  32'h0000_0000, 1, 5'd0,  5'd0,  1'b0};
    vecs[4] = '{"key31 press",   32'h8000_0000, 1, 5'd31, 5'd0,  1'b1};
    vecs[5] = '{"key31 release", 32'h0000_0000, 1, 5'd31, 5'd0,  1'b0};
    vecs[6] = '{"ghost press",   32'h0000_5000, GHOST_EV, 5'd12, 5'd14, 1'b1};
    vecs[7] = '{"ghost release", 32'h0000_0000, GHOST_EV, 5'd12, 5'd14, 1'b0};

    // Reset, run into the middle of a frame, then reset again asynchronously.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (37) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst col", {24'd0, col}, 32'hFF);
    chk("rst valid", {31'd0, key_valid}, 32'd0);
    chk("rst code", {27'd0, key_code}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst hold col", {24'd0, col}, 32'hFF);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("col after rst", {24'd0, col}, 32'hFE);
    repeat (14) @(posedge clk);
    #1;
    chk("col edge15", {24'd0, col}, 32'hFE);
    @(posedge clk); #1;
    chk("col edge16", {24'd0, col}, 32'hFD);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      pressed = vecs[v].mask;
      for (int e = 0; e < vecs[v].n_ev; e++)
        take_event(vecs[v].name, (e == 0) ? PRESS_BOUND : 2 * FRAME,
                   (e == 0) ? vecs[v].c0 : vecs[v].c1, vecs[v].down);
      expect_quiet(vecs[v].name, 4 * FRAME);
    end

    // Bounce: key 9 toggles every frame for 10 frames, then settles pressed.
    bad = 1'b0;
    for (int f = 0; f < 10; f++) begin
      pressed[9] = (f % 2 == 0);
      repeat (FRAME) begin
        @(negedge clk);
        if (key_valid) bad = 1'b1;
      end
    end
    chk("bounce no event", {31'd0, bad}, 32'd0);
    pressed[9] = 1'b1;
    take_event("bounce settle", PRESS_BOUND, 5'd9, 1'b1);
    expect_quiet("bounce settle", 4 * FRAME);
    pressed = '0;
    take_event("bounce release", PRESS_BOUND, 5'd9, 1'b0);

    // Backpressure: keys 5 and 30 pressed together, register not acknowledged.
    wait_col0();
    pressed = (32'd1 << 5) | (32'd1 << 30);
    wait_event(PRESS_BOUND, got);
    chk("bp valid", {31'd0, got}, 32'd1);
    chk("bp code", {27'd0, key_code}, 32'd5);
    chk("bp down", {31'd0, key_down}, 32'd1);
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (!key_valid || key_code != 5'd5 || !key_down) bad = 1'b1;
    end
    chk("bp hold", {31'd0, bad}, 32'd0);
    ack_pulse("bp ack");
    take_event("bp second", FRAME + 2, 5'd30, 1'b1);
    expect_quiet("bp pressed", 4 * FRAME);
    wait_col0();
    pressed = '0;
    take_event("bp rel5", PRESS_BOUND, 5'd5, 1'b0);
    take_event("bp rel30", 2 * FRAME, 5'd30, 1'b0);

    // Reset while an event is pending; the held key is reported again afterwards.
    @(negedge clk);
    pressed = 32'd1 << 9;
    wait_event(PRESS_BOUND, got);
    chk("rme valid", {31'd0, got}, 32'd1);
    chk("rme code", {27'd0, key_code}, 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rme rst valid", {31'd0, key_valid}, 32'd0);
    chk("rme rst code", {27'd0, key_code}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    take_event("rme repress", PRESS_BOUND, 5'd9, 1'b1);
    pressed = '0;
    take_event("rme release", PRESS_BOUND, 5'd9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
